seq_booth_divider: RTL and testbench
====================================

# seq_booth_divider

Sequential restoring divider: the inverse of the team's combinational Booth multiplier. It splits a 2N-bit dividend by an N-bit divisor into a 2N-bit quotient and an N-bit remainder, producing one quotient bit per clock. Signed (two's-complement) and unsigned modes are supported. The block uses a start/busy/done handshake and sits beside the multiplier in the arithmetic datapath behind the same tile I/O.

## Interface
- N, default 4: divisor/remainder width; dividend/quotient width is 2N.
- clk  input  1  rising-edge clock, single domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- dividend  input  2N  captured on the accepting edge.
- divisor  input  N  captured on the accepting edge.
- quotient  output  2N  result; held until the next accepted start.
- remainder  output  N  result; held until the next accepted start.
- busy  output  1  high in RUN and FIX.
- done  output  1  one-cycle pulse in DONE.
- dbz  output  1  divide-by-zero flag; valid with done, held with results.
- ovf  output  1  signed overflow flag; valid with done, held with results.

## Operation
- States: IDLE, RUN, FIX, DONE.
- Reset (rst=1 at an edge):
  - state becomes IDLE;
  - quotient, remainder, busy, done, dbz and ovf all become 0;
  - an in-flight division is aborted and no done is issued.
- Accept (start=1 in IDLE or DONE):
  - capture operands and signed_mode;
  - capture the magnitudes (abs when signed_mode=1, raw when unsigned);
  - record the quotient sign (sign XOR) and the remainder sign (dividend sign);
  - clear dbz, ovf and the iteration counter;
  - go to RUN.
- Divisor zero on accept: skip RUN and FIX and go straight to DONE with quotient all ones, remainder 0, dbz=1, ovf=0.
- RUN, one iteration per edge for 2N edges, MSB first:
  - partial remainder P (N+1 bits) = {P, next dividend bit};
  - if P ≥ |divisor|: P -= |divisor| and the quotient bit is 1; otherwise the quotient bit is 0;
  - after iteration 2N-1, go to FIX.
- FIX, one edge:
  - negate the quotient if the quotient sign is negative;
  - negate the remainder if the dividend is negative;
  - signed_mode=1 with dividend = -2^(2N-1) and divisor = -1: quotient = 2^(2N-1) bit pattern (wraps), remainder 0, ovf=1;
  - go to DONE.
- Signed semantics: quotient truncates toward zero, remainder takes the sign of the dividend, and quotient×divisor + remainder = dividend holds (except in the ovf case).
- DONE:
  - done=1 for exactly one cycle;
  - start=1 starts the next division back-to-back;
  - otherwise go to IDLE;
  - outputs hold in IDLE.
- start while busy=1 is ignored; no queueing.
- Operand changes after the accepting edge have no effect.

## Timing
- Accept at edge k.
- busy: high after edge k through edge k+2N+1 (2N+1 cycles).
- done: high in the cycle after edge k+2N+1. Latency is 2N+2 edges from the accepting edge, so 10 cycles for N=4.
- Divide-by-zero: done high in the cycle after edge k (1-cycle latency), busy never asserts.
- quotient, remainder, dbz and ovf:
  - change only at the FIX edge (or at the accept edge for dbz, or at reset);
  - are stable whenever done=1 and afterwards;
  - intermediate RUN values live in internal registers and are not visible on the outputs.
- rst=1 together with start=1: reset wins and start is dropped.
- Back-to-back: start in the DONE cycle sets busy=1 the next cycle, and the previous results stay on the outputs until the new FIX edge.

## Test plan
- Unsigned, N=4: dividend=0xC8 (200), divisor=0x7, signed_mode=0 -> after 10 cycles done=1, quotient=0x1C (28), remainder=0x4, dbz=0, ovf=0.
- Signed: dividend=0x9C (-100), divisor=0x7 -> quotient=0xF2 (-14), remainder=0xE (-2). Then dividend=0x64 (100), divisor=0x9 (-7) -> quotient=0xF2, remainder=0x2.
- Divide-by-zero: dividend=0x37, divisor=0x0 -> done in the cycle after accept, dbz=1, quotient=0xFF, remainder=0x0, busy never 1.
- Signed overflow: dividend=0x80, divisor=0xF, signed_mode=1 -> quotient=0x80, remainder=0x0, ovf=1. The same operands with signed_mode=0 give quotient=0x08, remainder=0x8, ovf=0.
- Handshake:
  - start pulsed during RUN is ignored and the first result is unchanged;
  - operands changed mid-RUN have no effect;
  - start held high in DONE gives the second done exactly 10 cycles after the first.
- Reset mid-operation: assert rst at RUN iteration 3 -> next cycle all outputs are 0 and state is IDLE, no done pulse; a fresh division then completes normally.

Source files
------------

// File: rtl/seq_booth_divider.sv
// rtl/seq_booth_divider.sv - sequential restoring divider, 2N/N bits, signed or unsigned, one quotient bit per clock
module seq_booth_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(2 * N - 1);
    localparam logic [2*N-1:0]   MIN_DVD   = {1'b1, {(2 * N - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic [2*N-1:0] acc;
    logic [N-1:0]   p;
    logic [N-1:0]   dvs_mag;
    logic [CW-1:0]  cnt;
    logic           q_neg;
    logic           r_neg;
    logic           ovf_pend;

    logic           accept;
    logic           dvd_neg;
    logic           dvs_neg;
    logic           dvs_zero;
    logic [2*N-1:0] dvd_abs;
    logic [N-1:0]   dvs_abs;
    logic [N:0]     trial;
    logic           ge;
    logic [N-1:0]   p_nxt;

    always_comb begin
        dvd_neg  = signed_mode & dividend[2*N-1];
        dvs_neg  = signed_mode & divisor[N-1];
        dvs_zero = (divisor == '0);
        dvd_abs  = dvd_neg ? -dividend : dividend;
        dvs_abs  = dvs_neg ? -divisor : divisor;
    end

    // Acc shifts dividend bits out of the MSB while quotient bits enter at the LSB.
    always_comb begin
        trial = {p, acc[2*N-1]};
        ge    = (trial >= {1'b0, dvs_mag});
        p_nxt = ge ? N'(trial - {1'b0, dvs_mag}) : trial[N-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = dvs_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == LAST_ITER) begin
                    next_state = S_FIX;
                end
            end
            S_FIX: begin
                busy       = 1'b1;
                next_state = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = dvs_zero ? S_DONE : S_RUN;
                end else begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Visible results only move at FIX or on a divide-by-zero accept; RUN works on internal state.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            p         <= '0;
            dvs_mag   <= '0;
            cnt       <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
            ovf_pend  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            acc      <= dvd_abs;
            p        <= '0;
            dvs_mag  <= dvs_abs;
            cnt      <= '0;
            q_neg    <= dvd_neg ^ dvs_neg;
            r_neg    <= dvd_neg;
            ovf_pend <= signed_mode && (dividend == MIN_DVD) && (divisor == '1);
            if (dvs_zero) begin
                quotient  <= '1;
                remainder <= '0;
                dbz       <= 1'b1;
                ovf       <= 1'b0;
            end
        end else if (state == S_RUN) begin
            acc <= {acc[2*N-2:0], ge};
            p   <= p_nxt;
            cnt <= cnt + CW'(1);
        end else if (state == S_FIX) begin
            quotient  <= q_neg ? -acc : acc;
            remainder <= r_neg ? -p : p;
            dbz       <= 1'b0;
            ovf       <= ovf_pend;
        end
    end

endmodule

// File: tb/tb_seq_booth_divider.sv
// tb/tb_seq_booth_divider.sv - directed self-checking bench for seq_booth_divider
module tb_seq_booth_divider;

    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic           signed_mode;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           dbz;
    logic           ovf;

    int total;
    int bad;

    seq_booth_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .dbz         (dbz),
        .ovf         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // lat counts the accepting edge as 1; stops at the first cycle with done=1 or at 40.
    task automatic run_div(input logic [7:0] a, input logic [3:0] b, input logic sm,
                           output int lat, output int busy_seen);
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        start       = 1'b1;
        step();
        start     = 1'b0;
        lat       = 1;
        busy_seen = int'(busy);
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
            if (busy === 1'b1) busy_seen = 1;
        end
    endtask

    task automatic test_reset();
        total++; if (quotient !== 8'h00) begin bad++; $display("FAIL reset_q got=%h want=00", quotient); end
        total++; if (remainder !== 4'h0) begin bad++; $display("FAIL reset_r got=%h want=0", remainder); end
        total++; if ({busy, done, dbz, ovf} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {busy, done, dbz, ovf}); end
    endtask

    task automatic test_unsigned();
        int lat, bs;
        run_div(8'hC8, 4'h7, 1'b0, lat, bs);
        total++; if (lat != 10) begin bad++; $display("FAIL unsigned_latency got=%0d want=10", lat); end
        total++; if (quotient !== 8'h1C) begin bad++; $display("FAIL unsigned_q got=%h want=1c", quotient); end
        total++; if (remainder !== 4'h4) begin bad++; $display("FAIL unsigned_r got=%h want=4", remainder); end
        total++; if ({dbz, ovf} !== 2'b00) begin bad++; $display("FAIL unsigned_flags got=%b want=00", {dbz, ovf}); end
        step();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL unsigned_idle got=%b want=00", {busy, done}); end
        total++; if (quotient !== 8'h1C) begin bad++; $display("FAIL unsigned_hold got=%h want=1c", quotient); end
    endtask

    task automatic test_signed();
        int lat, bs;
        run_div(8'h9C, 4'h7, 1'b1, lat, bs);
        total++; if (lat != 10) begin bad++; $display("FAIL signed1_latency got=%0d want=10", lat); end
        total++; if (quotient !== 8'hF2) begin bad++; $display("FAIL signed1_q got=%h want=f2", quotient); end
        total++; if (remainder !== 4'hE) begin bad++; $display("FAIL signed1_r got=%h want=e", remainder); end
        run_div(8'h64, 4'h9, 1'b1, lat, bs);
        total++; if (quotient !== 8'hF2) begin bad++; $display("FAIL signed2_q got=%h want=f2", quotient); end
        total++; if (remainder !== 4'h2) begin bad++; $display("FAIL signed2_r got=%h want=2", remainder); end
        total++; if ({dbz, ovf} !== 2'b00) begin bad++; $display("FAIL signed2_flags got=%b want=00", {dbz, ovf}); end
    endtask

    task automatic test_dbz();
        int lat, bs;
        run_div(8'h37, 4'h0, 1'b0, lat, bs);
        total++; if (lat != 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat); end
        total++; if (bs != 0) begin bad++; $display("FAIL dbz_busy got=%0d want=0", bs); end
        total++; if (quotient !== 8'hFF) begin bad++; $display("FAIL dbz_q got=%h want=ff", quotient); end
        total++; if (remainder !== 4'h0) begin bad++; $display("FAIL dbz_r got=%h want=0", remainder); end
        total++; if ({dbz, ovf} !== 2'b10) begin bad++; $display("FAIL dbz_flags got=%b want=10", {dbz, ovf}); end
    endtask

    task automatic test_ovf();
        int lat, bs;
        run_div(8'h80, 4'hF, 1'b1, lat, bs);
        total++; if (quotient !== 8'h80) begin bad++; $display("FAIL ovf_q got=%h want=80", quotient); end
        total++; if (remainder !== 4'h0) begin bad++; $display("FAIL ovf_r got=%h want=0", remainder); end
        total++; if ({dbz, ovf} !== 2'b01) begin bad++; $display("FAIL ovf_flags got=%b want=01", {dbz, ovf}); end
        run_div(8'h80, 4'hF, 1'b0, lat, bs);
        total++; if (quotient !== 8'h08) begin bad++; $display("FAIL ovf_unsigned_q got=%h want=08", quotient); end
        total++; if (remainder !== 4'h8) begin bad++; $display("FAIL ovf_unsigned_r got=%h want=8", remainder); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_unsigned_flag got=%b want=0", ovf); end
    endtask

    task automatic test_handshake();
        int lat;
        dividend    = 8'hC8;
        divisor     = 4'h7;
        signed_mode = 1'b0;
        start       = 1'b1;
        step();
        start = 1'b0;
        lat   = 1;
        step();
        step();
        lat += 2;
        start       = 1'b1;
        dividend    = 8'h64;
        divisor     = 4'h9;
        signed_mode = 1'b1;
        step();
        lat++;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL hs_busy got=%b want=1", busy); end
        total++; if (quotient !== 8'h08) begin bad++; $display("FAIL hs_prev_hold got=%h want=08", quotient); end
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        total++; if (lat != 10) begin bad++; $display("FAIL hs_latency got=%0d want=10", lat); end
        total++; if (quotient !== 8'h1C) begin bad++; $display("FAIL hs_q got=%h want=1c", quotient); end
        total++; if (remainder !== 4'h4) begin bad++; $display("FAIL hs_r got=%h want=4", remainder); end
        step();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL hs_no_second got=%b want=00", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        int lat, lat2;
        dividend    = 8'hC8;
        divisor     = 4'h7;
        signed_mode = 1'b0;
        start       = 1'b1;
        step();
        lat         = 1;
        dividend    = 8'h9C;
        signed_mode = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        total++; if (lat != 10) begin bad++; $display("FAIL b2b_first_latency got=%0d want=10", lat); end
        total++; if (quotient !== 8'h1C) begin bad++; $display("FAIL b2b_first_q got=%h want=1c", quotient); end
        step();
        lat2  = 1;
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
        total++; if (quotient !== 8'h1C) begin bad++; $display("FAIL b2b_hold got=%h want=1c", quotient); end
        while (done !== 1'b1 && lat2 < 40) begin
            step();
            lat2++;
        end
        total++; if (lat2 != 10) begin bad++; $display("FAIL b2b_gap got=%0d want=10", lat2); end
        total++; if (quotient !== 8'hF2) begin bad++; $display("FAIL b2b_second_q got=%h want=f2", quotient); end
        total++; if (remainder !== 4'hE) begin bad++; $display("FAIL b2b_second_r got=%h want=e", remainder); end
    endtask

    task automatic test_reset_mid();
        int lat, bs, done_seen;
        dividend    = 8'hC8;
        divisor     = 4'h7;
        signed_mode = 1'b0;
        start       = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (quotient !== 8'h00 || remainder !== 4'h0) begin bad++; $display("FAIL rstmid_result got=%h/%h want=00/0", quotient, remainder); end
        total++; if ({busy, done, dbz, ovf} !== 4'b0000) begin bad++; $display("FAIL rstmid_flags got=%b want=0000", {busy, done, dbz, ovf}); end
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_with_start got=%b want=00", {busy, done}); end
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) done_seen = 1;
        end
        total++; if (done_seen != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", done_seen); end
        run_div(8'h64, 4'h9, 1'b1, lat, bs);
        total++; if (lat != 10) begin bad++; $display("FAIL rstmid_fresh_latency got=%0d want=10", lat); end
        total++; if (quotient !== 8'hF2 || remainder !== 4'h2) begin bad++; $display("FAIL rstmid_fresh got=%h/%h want=f2/2", quotient, remainder); end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_dbz();
        test_ovf();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
